// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: multi-cycle adder/subtractor that processes CHUNK bits
// per clock, LSB chunk first, carrying between chunks through a register.
// A start/done handshake lets a controlling FSM launch one operation at a time.
module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             accept_s;
  logic             last_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] psum_r;
  logic [WIDTH-1:0] psum_next_s;
  logic             carry_r;
  logic [IDX_W-1:0] idx_r;
  logic [31:0]      base_s;
  logic [CHUNK-1:0] a_chunk_s;
  logic [CHUNK-1:0] b_chunk_s;
  logic [CHUNK:0]   chunk_sum_s;
  logic             carry_msb_s;

  // Next-state decode plus the accept and final-chunk strobes
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
          accept_s     = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (idx_r == LAST_IDX) begin
          state_next_s = DONE;
          last_s       = 1'b1;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_next_s = RUN;
          accept_s     = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // One chunk of addition; the carry into the chunk MSB is recovered as a^b^s
  always_comb begin
    base_s      = 32'(idx_r) * 32'(CHUNK);
    a_chunk_s   = CHUNK'(a_r >> base_s);
    b_chunk_s   = CHUNK'(b_r >> base_s);
    chunk_sum_s = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_r};
    psum_next_s = (psum_r & ~(CHUNK_MASK << base_s))
                | (WIDTH'(chunk_sum_s[CHUNK-1:0]) << base_s);
    carry_msb_s = a_chunk_s[CHUNK-1] ^ b_chunk_s[CHUNK-1] ^ chunk_sum_s[CHUNK-1];
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture on accept, then chunk-by-chunk accumulation while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      psum_r  <= '0;
      carry_r <= 1'b0;
      idx_r   <= '0;
    end else if (accept_s) begin
      a_r     <= in1;
      b_r     <= sub ? ~in2 : in2;
      psum_r  <= '0;
      carry_r <= sub ? 1'b1 : c_in;
      idx_r   <= '0;
    end else if (state_r == RUN) begin
      psum_r  <= psum_next_s;
      carry_r <= chunk_sum_s[CHUNK];
      idx_r   <= last_s ? '0 : idx_r + IDX_W'(1);
    end else begin
      idx_r   <= idx_r;
    end
  end

  // Registered status flags; results only move on the final chunk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      busy <= (state_next_s == RUN);
      done <= last_s;
      if (last_s) begin
        sum      <= psum_next_s;
        c_out    <= chunk_sum_s[CHUNK];
        overflow <= carry_msb_s ^ chunk_sum_s[CHUNK];
      end else begin
        sum      <= sum;
      end
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed bench for chunked_serial_adder across four width/chunk configurations.
module tb_chunked_serial_adder;

  logic        clk;
  logic        rst;
  logic [3:0]  start_v;
  logic        sub;
  logic        c_in;
  logic [31:0] in1;
  logic [31:0] in2;
  int          sel;

  logic        busy_a, done_a, c_a, ov_a;
  logic [31:0] sum_a;
  logic        busy_b, done_b, c_b, ov_b;
  logic [7:0]  sum_b;
  logic        busy_c, done_c, c_c, ov_c;
  logic [15:0] sum_c;
  logic        busy_d, done_d, c_d, ov_d;
  logic [15:0] sum_d;

  logic        obs_busy, obs_done, obs_c, obs_ov;
  logic [31:0] obs_sum;

  int errors;
  int checks;

  chunked_serial_adder #(.WIDTH(32), .CHUNK(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub), .in1(in1), .in2(in2),
    .c_in(c_in), .busy(busy_a), .done(done_a), .sum(sum_a), .c_out(c_a), .overflow(ov_a));

  chunked_serial_adder #(.WIDTH(8), .CHUNK(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub), .in1(in1[7:0]), .in2(in2[7:0]),
    .c_in(c_in), .busy(busy_b), .done(done_b), .sum(sum_b), .c_out(c_b), .overflow(ov_b));

  chunked_serial_adder #(.WIDTH(16), .CHUNK(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub), .in1(in1[15:0]), .in2(in2[15:0]),
    .c_in(c_in), .busy(busy_c), .done(done_c), .sum(sum_c), .c_out(c_c), .overflow(ov_c));

  chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) dut_d (
    .clk(clk), .rst(rst), .start(start_v[3]), .sub(sub), .in1(in1[15:0]), .in2(in2[15:0]),
    .c_in(c_in), .busy(busy_d), .done(done_d), .sum(sum_d), .c_out(c_d), .overflow(ov_d));

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the selected instance's outputs to a common observation point
  always_comb begin
    obs_busy = busy_a; obs_done = done_a; obs_c = c_a; obs_ov = ov_a; obs_sum = sum_a;
    case (sel)
      1: begin obs_busy = busy_b; obs_done = done_b; obs_c = c_b; obs_ov = ov_b; obs_sum = {24'd0, sum_b}; end
      2: begin obs_busy = busy_c; obs_done = done_c; obs_c = c_c; obs_ov = ov_c; obs_sum = {16'd0, sum_c}; end
      3: begin obs_busy = busy_d; obs_done = done_d; obs_c = c_d; obs_ov = ov_d; obs_sum = {16'd0, sum_d}; end
      default: begin obs_busy = busy_a; obs_done = done_a; obs_c = c_a; obs_ov = ov_a; obs_sum = sum_a; end
    endcase
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent reference: whole-word arithmetic, overflow from operand/result signs
  task automatic model(input int w, input logic sb, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, output logic [31:0] s, output logic c, output logic v);
    logic [31:0] mask, aa, bb;
    logic [32:0] full;
    logic        cin;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    aa   = a & mask;
    bb   = sb ? (~b & mask) : (b & mask);
    cin  = sb ? 1'b1 : ci;
    full = {1'b0, aa} + {1'b0, bb} + {32'd0, cin};
    s    = full[31:0] & mask;
    c    = full[w];
    v    = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
  endtask

  // Launch one operation on instance s and check latency, busy and results
  task automatic run_op(input int s, input logic sb, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input int exp_lat, input logic [31:0] exp_sum,
                        input logic exp_c, input logic exp_v, input string tag);
    int lat;
    int busy_bad;
    sel = s;
    @(negedge clk);
    sub = sb; in1 = a; in2 = b; c_in = ci;
    start_v = 4'd0;
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v = 4'd0;
    lat = 0;
    busy_bad = 0;
    if (!obs_busy) busy_bad++;
    while (!obs_done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!obs_done && !obs_busy) busy_bad++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_sum"}, 64'(obs_sum), 64'(exp_sum));
    check_eq({tag, "_cout"}, 64'(obs_c), 64'(exp_c));
    check_eq({tag, "_ovf"}, 64'(obs_ov), 64'(exp_v));
    check_eq({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
    check_eq({tag, "_busy_done"}, 64'(obs_busy), 64'd0);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 64'(obs_done), 64'd0);
  endtask

  initial begin
    int lat, k, first_lat, second, hold_bad, dones;
    logic [31:0] es, ra, rb;
    logic ec, ev, rs, rc;
    int cfg_sel [3] = '{0, 2, 3};
    int cfg_w   [3] = '{32, 16, 16};
    int cfg_n   [3] = '{8, 16, 1};

    errors = 0; checks = 0; sel = 0;
    start_v = 4'd0; sub = 1'b0; c_in = 1'b0; in1 = 32'd0; in2 = 32'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_sum", 64'(obs_sum), 64'd0);
    check_eq("rst_cout", 64'(obs_c), 64'd0);
    check_eq("rst_ovf", 64'(obs_ov), 64'd0);
    check_eq("rst_busy", 64'(obs_busy), 64'd0);
    check_eq("rst_done", 64'(obs_done), 64'd0);

    run_op(0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 8, 32'h0000_0000, 1'b1, 1'b0, "add_cout");
    run_op(1, 1'b0, 32'h7F, 32'h01, 1'b0, 2, 32'h80, 1'b0, 1'b1, "w8_ovf");
    run_op(1, 1'b1, 32'h05, 32'h07, 1'b0, 2, 32'hFE, 1'b0, 1'b0, "w8_borrow");
    run_op(1, 1'b1, 32'h80, 32'h01, 1'b1, 2, 32'h7F, 1'b1, 1'b1, "w8_subovf");
    run_op(3, 1'b0, 32'h8000, 32'h8000, 1'b0, 1, 32'h0000, 1'b1, 1'b1, "w16c16");
    run_op(2, 1'b0, 32'hFFFF, 32'h0001, 1'b0, 16, 32'h0000, 1'b1, 1'b0, "w16c1_add");
    run_op(2, 1'b1, 32'h0000, 32'h0001, 1'b1, 16, 32'hFFFF, 1'b0, 1'b0, "w16c1_sub");

    // Start pulsed mid-run is ignored, then a back-to-back start in the DONE cycle
    sel = 0;
    @(negedge clk);
    in1 = 32'h1234_5678; in2 = 32'h1111_1111; sub = 1'b0; c_in = 1'b0; start_v = 4'b0001;
    @(negedge clk);
    start_v = 4'd0;
    lat = 0;
    first_lat = -1;
    while (lat < 40 && first_lat < 0) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        start_v = 4'b0001; in1 = 32'hFFFF_FFFF; in2 = 32'hFFFF_FFFF; sub = 1'b1;
      end else begin
        start_v = 4'd0;
      end
      if (obs_done) first_lat = lat;
    end
    check_eq("ign_lat", 64'(first_lat), 64'd8);
    check_eq("ign_sum", 64'(obs_sum), 64'h2345_6789);
    in1 = 32'h1; in2 = 32'h1; sub = 1'b0; c_in = 1'b0; start_v = 4'b0001;
    k = 0;
    second = -1;
    hold_bad = 0;
    while (k < 40 && second < 0) begin
      @(negedge clk);
      k++;
      start_v = 4'd0;
      if (obs_done) second = k;
      else if (obs_sum != 32'h2345_6789) hold_bad++;
    end
    check_eq("b2b_gap", 64'(second), 64'd9);
    check_eq("b2b_hold", 64'(hold_bad), 64'd0);
    check_eq("b2b_sum", 64'(obs_sum), 64'h2);

    // Asynchronous reset during the fourth RUN cycle
    @(negedge clk);
    in1 = 32'hAAAA_AAAA; in2 = 32'h5555_5555; start_v = 4'b0001;
    @(negedge clk);
    start_v = 4'd0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_sum", 64'(obs_sum), 64'd0);
    check_eq("arst_busy", 64'(obs_busy), 64'd0);
    check_eq("arst_done", 64'(obs_done), 64'd0);
    check_eq("arst_cout", 64'(obs_c), 64'd0);
    check_eq("arst_ovf", 64'(obs_ov), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (obs_done) dones++;
    end
    check_eq("arst_nodone", 64'(dones), 64'd0);
    run_op(0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 8, 32'h8000_0000, 1'b0, 1'b1, "post_rst");

    // Random operands against the whole-word reference
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 6; i++) begin
        ra = $urandom;
        rb = $urandom;
        rs = 1'($urandom_range(1, 0));
        rc = 1'($urandom_range(1, 0));
        model(cfg_w[c], rs, ra, rb, rc, es, ec, ev);
        run_op(cfg_sel[c], rs, ra, rb, rc, cfg_n[c], es, ec, ev, "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chunked_serial_adder.md
# chunked_serial_adder

- Multi-cycle, parametrised successor to the single-bit full adder used in the ripple carry adder work.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, with the inter-chunk carry held in a register.
- Offers a small-area alternative to a full-width ripple carry adder, with a start/done handshake for use under a controlling FSM.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state and outputs immediately.
- start  in  1  request; sampled on rising edge, accepted only in IDLE or DONE.
- sub  in  1  0 = in1 + in2 + c_in; 1 = in1 - in2 (c_in ignored).
- in1  in  WIDTH  operand A; captured on accepted start.
- in2  in  WIDTH  operand B; captured on accepted start.
- c_in  in  1  carry-in for add mode; captured on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result; holds last value until next accepted start completes.
- c_out  out  1  carry out of MSB; in subtract mode 1 = no borrow.
- overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
  - Reset state is IDLE.
  - IDLE/DONE with start=1 -> RUN.
  - RUN after the N-th chunk -> DONE.
  - DONE with start=0 -> IDLE.
- On accepted start:
  - Latch in1 into A.
  - Latch in2 into B; if sub=1, latch ~in2 instead.
  - Load the carry register with c_in, or with 1 if sub=1.
  - Clear chunk index to 0.
  - Clear the internal partial-sum register.
- Each RUN cycle:
  - Compute {carry, psum} = A[idx*CHUNK +: CHUNK] + B[idx*CHUNK +: CHUNK] + carry.
  - Write psum into the partial register at the same slice.
  - Increment idx.
- Final chunk (idx = N-1):
  - Also record the carry into the MSB (carry out of bit WIDTH-2) for overflow.
  - Latch the partial register to sum, final carry to c_out, and the overflow bit.
- Inputs are ignored while in RUN: start, sub, in1, in2 and c_in have no effect until DONE.
- Index counter wraps cleanly: it is reloaded to 0 on each accepted start and is never compared past N-1.
- Async reset mid-RUN:
  - Aborts the operation and returns to IDLE.
  - Clears all outputs to 0.
  - No done pulse is produced for the aborted operation.
- Start and rst both high: rst wins.

## Timing
- Reset values: sum=0, c_out=0, overflow=0, busy=0, done=0.
- Start sampled at edge E0: busy=1 from E0 to E_N.
- At E_N: sum, c_out and overflow update, done=1, busy=0.
- Latency is exactly N cycles from the start edge to done visible; default N=8.
- done is high for exactly one cycle (E_N to E_N+1).
- Back-to-back operations:
  - start=1 during the DONE cycle is accepted at E_N+1.
  - Throughput is one result per N+1 cycles with no IDLE gap.
- sum, c_out and overflow are stable from done until the next done; they do not change during RUN.

## Test plan
- Add with carry-out, WIDTH=32/CHUNK=4:
  - Stimulus: start with in1=0xFFFFFFFF, in2=0x00000000, c_in=1, sub=0.
  - Required: done exactly 8 cycles after the start edge; sum=0x00000000, c_out=1, overflow=0; busy high for the 8 cycles.
- Signed overflow and subtract, WIDTH=8/CHUNK=4:
  - 0x7F + 0x01 (c_in=0) -> sum=0x80, c_out=0, overflow=1, done 2 cycles after start.
  - sub=1, 0x05 - 0x07 -> sum=0xFE, c_out=0 (borrow), overflow=0.
  - sub=1, 0x80 - 0x01 -> sum=0x7F, c_out=1, overflow=1.
- Start ignored while busy:
  - Stimulus: start 0x12345678 + 0x11111111; at cycle 3 pulse start with different operands.
  - Required: single done at cycle 8 with sum=0x23456789; no second done.
- Back-to-back:
  - Stimulus: assert start in the DONE cycle with 0x00000001 + 0x00000001.
  - Required: previous result holds during RUN; next done 9 cycles after the first done, with sum=0x00000002.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously (between edges) during cycle 4 of RUN.
  - Required: all outputs are 0 immediately; no done pulse; a following start completes normally in 8 cycles.
- Randomised check against in1+in2+c_in and in1-in2:
  - Configs: WIDTH=16/CHUNK=1, WIDTH=16/CHUNK=16 (N=1, done 1 cycle after start), and default.
  - Required: sum, c_out and overflow match the reference model on every done.
